stft_framer: RTL
================

# stft_framer

Parametrised framing stage between the ADC sample interface and the FFT in the Shazam core. It accepts unsigned offset-binary ADC samples and converts them to left-aligned signed samples. The samples are stored in a ring buffer. The block emits overlapping frames of `FFT_LENGTH` samples every `HOP` input samples over a valid/ready stream. It generalises the fixed, non-overlapped 1024-point, 12-bit capture path to any width, length and hop, and adds backpressure and overrun reporting.

## Interface

- `ADC_WIDTH`, 12, width of the unsigned ADC sample.
- `OUT_WIDTH`, 16, width of the signed output sample; must be >= `ADC_WIDTH`.
- `FFT_LENGTH`, 1024, samples per frame; power of two, >= 4.
- `HOP`, 512, new input samples between frame starts; 1 <= `HOP` <= `FFT_LENGTH`.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `start` input 1: level enable; framing runs while high.
- `adc_data_valid` input 1: one-cycle strobe, `adc_data` valid.
- `adc_data` input `ADC_WIDTH`: unsigned offset-binary sample.
- `sample_out` output `OUT_WIDTH`: signed frame sample.
- `sample_valid` output 1: `sample_out`/`sample_index`/`frame_last` valid.
- `sample_ready` input 1: downstream accepts when high with `sample_valid`.
- `sample_index` output `$clog2(FFT_LENGTH)`: position within frame, 0..`FFT_LENGTH`-1.
- `frame_last` output 1: high with index `FFT_LENGTH`-1.
- `frame_count` output 16: frames fully emitted, wraps at 2^16.
- `overrun` output 1: sticky; set when a sample or frame is dropped.
- `busy` output 1: a frame is being emitted or is pending.

## Operation

- Conversion at write:
  - `s = (adc_data - 2^(ADC_WIDTH-1)) * 2^(OUT_WIDTH-ADC_WIDTH)`, two's complement.
  - Low bits are zero.
- Ring buffer:
  - Depth `2*FFT_LENGTH`, single write port, synchronous read port.
  - Write pointer advances once per accepted `adc_data_valid`.
- Fill counter:
  - Counts accepted samples since `start` rose.
  - The first frame triggers when the counter reaches `FFT_LENGTH`.
  - Each later frame triggers after a further `HOP` samples.
  - A frame's base is the write pointer minus `FFT_LENGTH`, taken at the trigger.
- Frame queue holds one active frame and at most one pending frame.
  - A trigger while both slots are occupied drops the new frame and sets `overrun`.
- State machine:
  - IDLE: no frame. A trigger goes to EMIT.
  - EMIT: read base..base+`FFT_LENGTH`-1, one address per accepted output. The accepted `frame_last` increments `frame_count`. Go to EMIT with the pending frame if one exists, else IDLE.
- Overwrite guard: if the unread occupancy of the active frame equals `2*FFT_LENGTH`, the incoming sample is dropped, the write pointer is held and `overrun` is set.
- `start` low:
  - Samples are ignored.
  - The pending frame is discarded.
  - The active frame finishes emitting.
  - The fill counter clears.
  - The write pointer is kept.
- `overrun` clears only on reset or on a rising edge of `start`.
- Pointers wrap modulo `2*FFT_LENGTH`. Occupancy uses one extra bit to tell full from empty.

## Timing

- Reset values: `sample_valid`=0, `sample_out`=0, `sample_index`=0, `frame_last`=0, `frame_count`=0, `overrun`=0, `busy`=0; pointers, counters and queue cleared.
  - Reset assertion clears the outputs immediately, including mid-frame.
- Write: the sample is in RAM the cycle after `adc_data_valid`. A sample written in cycle t is readable from t+1.
- Trigger to first `sample_valid`: 2 cycles (one to register the trigger, one for RAM read). `busy` rises the cycle after the trigger.
- With `sample_ready` held high, a frame occupies `FFT_LENGTH` consecutive cycles. Back-to-back frames have no gap.
- Handshake:
  - Transfer happens on cycles with `sample_valid && sample_ready`.
  - While `sample_valid && !sample_ready`, all output fields stay stable.
  - `sample_valid` never drops without a transfer, except on reset.
- Trigger coincident with the final transfer of the active frame: the new frame becomes active directly, not dropped.
- Write and read of the same address in one cycle: the read returns the old data. The guard keeps this from happening for active-frame samples.

## Test plan

- `FFT_LENGTH`=16, `HOP`=16: 16 samples with `adc_data`=2048+k, strobes 21 cycles apart, ready high. Expect one frame with `sample_out`=16*k, `sample_index`=k, `frame_last` at k=15, `frame_count`=1.
- `HOP`=8: 32 ramp samples. Expect 3 frames with first samples from inputs 0, 8 and 16, and `frame_count`=3.
- Backpressure: `sample_ready` high 1 cycle in 3 during the frames of the previous test. Expect an identical sequence, stable fields while stalled, no `overrun`.
- Overrun: `HOP`=4, ready low, continuous samples. Expect `overrun` set when occupancy reaches 32, and `busy`=1. After ready is released, exactly the queued frames are emitted.
- Reset: `reset_n` low at `sample_index`=5. Expect all outputs 0 in the same cycle. After release and 16 new samples, a fresh frame starting at index 0.
- Extremes (12→16 bit): `adc_data`=0 → -32768; 2048 → 0; 4095 → 32752.

Source files
------------

// File: rtl/stft_framer.sv
// STFT framing stage: offset-binary ADC samples become left-aligned signed words in a
// 2*FFT_LENGTH ring buffer, replayed as overlapping FFT_LENGTH frames every HOP samples.
module stft_framer #(
  parameter int ADC_WIDTH  = 12,
  parameter int OUT_WIDTH  = 16,
  parameter int FFT_LENGTH = 1024,
  parameter int HOP        = 512
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          adc_data_valid,
  input  logic [ADC_WIDTH-1:0]          adc_data,
  output logic signed [OUT_WIDTH-1:0]   sample_out,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FFT_LENGTH)-1:0] sample_index,
  output logic                          frame_last,
  output logic [15:0]                   frame_count,
  output logic                          overrun,
  output logic                          busy
);

  localparam int IDX_W = $clog2(FFT_LENGTH);
  localparam int AW    = IDX_W + 1;
  localparam int PW    = AW + 1;
  localparam int CW    = IDX_W + 1;
  localparam int DEPTH = 2 * FFT_LENGTH;

  localparam logic [CW-1:0]        N_C      = CW'(FFT_LENGTH);
  localparam logic [CW-1:0]        N_M1     = CW'(FFT_LENGTH - 1);
  localparam logic [CW-1:0]        HOP_M1   = CW'(HOP - 1);
  localparam logic [PW-1:0]        N_P      = PW'(FFT_LENGTH);
  localparam logic [PW-1:0]        FULL_OCC = PW'(DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FFT_LENGTH - 1);
  localparam logic [ADC_WIDTH-1:0] ADC_MSB  = ADC_WIDTH'(1) << (ADC_WIDTH - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  // Flipping the MSB removes the mid-scale offset; the result is left-aligned.
  function automatic logic signed [OUT_WIDTH-1:0] conv_sample(input logic [ADC_WIDTH-1:0] x);
    logic signed [OUT_WIDTH-1:0] s;
    s = '0;
    s[OUT_WIDTH-1 -: ADC_WIDTH] = x ^ ADC_MSB;
    return s;
  endfunction

  state_t                      r_state;
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [PW-1:0]               r_tail;
  logic [PW-1:0]               r_pend_base;
  logic                        r_pend_vld;
  logic [CW-1:0]               r_issue;
  logic [CW-1:0]               r_fill;
  logic [CW-1:0]               r_hop;
  logic                        r_primed;
  logic                        r_start_d;
  logic                        r_overrun;
  logic [15:0]                 r_frame_cnt;
  logic                        r_vld_p1;
  logic                        r_last_p1;
  logic [IDX_W-1:0]            r_idx_p1;
  logic signed [OUT_WIDTH-1:0] r_q_p1;
  logic signed [OUT_WIDTH-1:0] r_mem [DEPTH];

  logic             w_emit;
  logic [PW-1:0]    w_occ;
  logic             w_guard;
  logic             w_accept;
  logic             w_trig;
  logic [PW-1:0]    w_base;
  logic             w_xfer;
  logic             w_finish;
  logic             w_pend;
  logic             w_next;
  logic [PW-1:0]    w_rd_addr;
  logic             w_load;
  logic [IDX_W-1:0] w_ld_idx;
  logic             w_drop_frame;
  logic             w_drop_smp;

  assign w_emit   = (r_state == S_EMIT);
  // Unread span of the active frame: from its oldest untransferred sample to the writer.
  assign w_occ    = r_wr_ptr - r_tail;
  assign w_guard  = w_emit && (w_occ == FULL_OCC);
  assign w_accept = start && adc_data_valid && !w_guard;
  assign w_trig   = w_accept && (r_primed ? (r_hop == HOP_M1) : (r_fill == N_M1));
  assign w_base   = r_wr_ptr + PW'(1) - N_P;

  assign w_xfer   = r_vld_p1 && sample_ready;
  assign w_finish = w_xfer && r_last_p1;
  assign w_pend   = r_pend_vld && start;
  // A queued frame starts reading in the same cycle the last word leaves, so frames abut.
  assign w_next    = w_finish && w_pend;
  assign w_rd_addr = w_next ? r_pend_base : r_rd_ptr;
  assign w_load    = w_emit && (w_next || (r_issue != N_C)) && (!r_vld_p1 || sample_ready);
  assign w_ld_idx  = w_next ? '0 : r_issue[IDX_W-1:0];

  assign w_drop_frame = w_trig && w_emit && r_pend_vld && !w_finish;
  assign w_drop_smp   = start && adc_data_valid && w_guard;

  // Write side: ring buffer storage and fill/hop counting
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr[AW-1:0]] <= conv_sample(adc_data);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_hop    <= '0;
      r_primed <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (!start) begin
        r_fill   <= '0;
        r_hop    <= '0;
        r_primed <= 1'b0;
      end else if (w_accept) begin
        if (w_trig) begin
          r_primed <= 1'b1;
          r_hop    <= '0;
        end else if (r_primed) begin
          r_hop <= r_hop + CW'(1);
        end else begin
          r_fill <= r_fill + CW'(1);
        end
      end
    end
  end

  // Frame control: one active frame plus one pending slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_tail      <= '0;
      r_issue     <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_base <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state  <= S_EMIT;
            r_rd_ptr <= w_base;
            r_tail   <= w_base;
            r_issue  <= '0;
          end
        end
        S_EMIT: begin
          if (w_xfer) r_tail <= r_tail + PW'(1);
          if (w_load) begin
            r_rd_ptr <= w_rd_addr + PW'(1);
            r_issue  <= CW'(w_ld_idx) + CW'(1);
          end
          if (w_finish) begin
            r_frame_cnt <= r_frame_cnt + 16'(1);
            if (w_pend) begin
              r_tail      <= r_pend_base;
              r_pend_vld  <= w_trig;
              r_pend_base <= w_base;
            end else if (w_trig) begin
              r_rd_ptr <= w_base;
              r_tail   <= w_base;
              r_issue  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_trig && !r_pend_vld) begin
            r_pend_vld  <= 1'b1;
            r_pend_base <= w_base;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (!start) r_pend_vld <= 1'b0;
    end
  end

  // Stage p1: synchronous RAM read doubles as the output register
  always_ff @(posedge clk) begin
    if (w_load) r_q_p1 <= r_mem[w_rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_idx_p1  <= '0;
    end else if (w_load) begin
      r_vld_p1  <= 1'b1;
      r_last_p1 <= (w_ld_idx == LAST_IDX);
      r_idx_p1  <= w_ld_idx;
    end else if (w_xfer) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= start;
      if (w_drop_frame || w_drop_smp) r_overrun <= 1'b1;
      else if (start && !r_start_d)   r_overrun <= 1'b0;
    end
  end

  assign sample_out   = r_vld_p1 ? r_q_p1 : '0;
  assign sample_valid = r_vld_p1;
  assign sample_index = r_idx_p1;
  assign frame_last   = r_last_p1;
  assign frame_count  = r_frame_cnt;
  assign overrun      = r_overrun;
  assign busy         = w_emit;

endmodule
